// File: rtl/regfile_sb_if.sv
// Issue/read/write-back bus of regfile_sb: master is the pipeline side, slave is the register file.
interface regfile_sb_if #(
  parameter int N    = 32,
  parameter int NREG = 16,
  parameter int AW   = 4
);
  logic [AW-1:0]   RA;
  logic [AW-1:0]   RB;
  logic [N-1:0]    DA;
  logic [N-1:0]    DB;
  logic            WE;
  logic [AW-1:0]   WA;
  logic [N-1:0]    WD;
  logic            IssueV;
  logic [AW-1:0]   IssueDst;
  logic            PendA;
  logic            PendB;
  logic            Stall;
  logic [NREG-1:0] PendMask;

  modport master (
    output RA, RB, WE, WA, WD, IssueV, IssueDst,
    input  DA, DB, PendA, PendB, Stall, PendMask
  );

  modport slave (
    input  RA, RB, WE, WA, WD, IssueV, IssueDst,
    output DA, DB, PendA, PendB, Stall, PendMask
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file (register 0 hardwired to zero) with per-register pending scoreboard and issue stall.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write-back to reads and pending lookups.
module regfile_sb #(
  parameter int N    = 32,
  parameter int NREG = 16,
  parameter int AW   = 4
) (
  input  logic         clk,
  input  logic         Clr_,
  regfile_sb_if.slave  bus
);

  logic [N-1:0]    mem [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_eff;
  logic [NREG-1:0] pend_next;
  logic [N-1:0]    da;
  logic [N-1:0]    db;
  logic            wr_ok;
  logic            pend_a;
  logic            pend_b;
  logic            pend_d;
  logic            stall;
  logic            issue_ok;

  assign wr_ok = bus.WE && (bus.WA != '0);

  always_comb begin
    pend_eff = pend;
`ifdef REGFILE_BYPASS_EN
    // A write-back landing this cycle already satisfies its consumers.
    if (wr_ok) pend_eff[bus.WA] = 1'b0;
`endif
  end

  always_comb begin
    da = (bus.RA == '0) ? '0 : mem[bus.RA];
    db = (bus.RB == '0) ? '0 : mem[bus.RB];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (bus.RA == bus.WA)) da = bus.WD;
    if (wr_ok && (bus.RB == bus.WA)) db = bus.WD;
`endif
  end

  assign pend_a   = pend_eff[bus.RA];
  assign pend_b   = pend_eff[bus.RB];
  assign pend_d   = pend_eff[bus.IssueDst];
  assign stall    = bus.IssueV && (pend_a || pend_b || pend_d);
  assign issue_ok = bus.IssueV && !stall && (bus.IssueDst != '0);

  // Issue set is applied after the write-back clear so it wins on a shared register.
  always_comb begin
    pend_next = pend;
    if (wr_ok)    pend_next[bus.WA]       = 1'b0;
    if (issue_ok) pend_next[bus.IssueDst] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge Clr_) begin
    if (!Clr_) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      pend <= '0;
    end else begin
      if (wr_ok) mem[bus.WA] <= bus.WD;
      pend <= pend_next;
    end
  end

  assign bus.DA       = da;
  assign bus.DB       = db;
  assign bus.PendA    = pend_a;
  assign bus.PendB    = pend_b;
  assign bus.Stall    = stall;
  assign bus.PendMask = pend;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected values, a monitor pops and compares.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int S_DA = 0, S_DB = 1, S_PA = 2, S_PB = 3, S_ST = 4, S_PM = 5;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic Clr_;
  exp_t sb[$];
  event chk_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  regfile_sb_if #(.N(32), .NREG(16), .AW(4)) bus ();

  regfile_sb #(.N(32), .NREG(16), .AW(4)) dut (
    .clk  (clk),
    .Clr_ (Clr_),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] get(int sig);
    case (sig)
      S_DA:    return bus.DA;
      S_DB:    return bus.DB;
      S_PA:    return {31'd0, bus.PendA};
      S_PB:    return {31'd0, bus.PendB};
      S_ST:    return {31'd0, bus.Stall};
      default: return {16'd0, bus.PendMask};
    endcase
  endfunction

  // Monitor: on every sample request, drain and compare the queued expectations.
  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = get(e.sig);
        n_cmp++;
        if (act !== e.val) begin
          n_bad++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic expect_v(string name, int sig, logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic sample();
    #2;
    -> chk_ev;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.RA = '0; bus.RB = '0;
    bus.WE = 1'b0; bus.WA = '0; bus.WD = '0;
    bus.IssueV = 1'b0; bus.IssueDst = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    Clr_ = 1'b1;
    #1 Clr_ = 1'b0;
    #1;
    expect_v("rst_da", S_DA, 32'h0);
    expect_v("rst_db", S_DB, 32'h0);
    expect_v("rst_mask", S_PM, 32'h0);
    expect_v("rst_pa", S_PA, 32'h0);
    expect_v("rst_pb", S_PB, 32'h0);
    expect_v("rst_stall", S_ST, 32'h0);
    -> chk_ev;
    #1;
    Clr_ = 1'b1;
    bus.WE = 1'b1; bus.WA = 4'd1; bus.WD = 32'h11;

    // First write after reset release lands normally.
    cyc(); idle();
    bus.RA = 4'd1;
    expect_v("post_rst_wr", S_DA, 32'h11);
    sample();

    cyc(); idle();
    bus.WE = 1'b1; bus.WA = 4'd5; bus.WD = 32'hDEADBEEF;
    bus.RA = 4'd5; bus.RB = 4'd1;
    expect_v("wr_same_cyc", S_DA, BYP ? 32'hDEADBEEF : 32'h0);
    expect_v("rd_r1", S_DB, 32'h11);
    sample();

    cyc(); idle();
    bus.RA = 4'd5;
    expect_v("wr_next_cyc", S_DA, 32'hDEADBEEF);
    sample();

    // Register 0: writes dropped, issue to it never marks pending.
    cyc(); idle();
    bus.WE = 1'b1; bus.WA = 4'd0; bus.WD = 32'h1234;
    bus.IssueV = 1'b1; bus.IssueDst = 4'd0;
    expect_v("r0_da_wcyc", S_DA, 32'h0);
    expect_v("r0_stall", S_ST, 32'h0);
    sample();

    cyc(); idle();
    expect_v("r0_da", S_DA, 32'h0);
    expect_v("r0_mask", S_PM, 32'h0);
    sample();

    // RAW hazard on source B.
    cyc(); idle();
    bus.IssueV = 1'b1; bus.IssueDst = 4'd3; bus.RA = 4'd1; bus.RB = 4'd5;
    expect_v("issue3_stall", S_ST, 32'h0);
    sample();

    cyc(); idle();
    bus.IssueV = 1'b1; bus.IssueDst = 4'd4; bus.RB = 4'd3;
    expect_v("raw_mask", S_PM, 32'h0008);
    expect_v("raw_pb", S_PB, 32'h1);
    expect_v("raw_pa", S_PA, 32'h0);
    expect_v("raw_stall", S_ST, 32'h1);
    sample();

    cyc(); idle();
    bus.IssueV = 1'b1; bus.IssueDst = 4'd4; bus.RB = 4'd3;
    bus.WE = 1'b1; bus.WA = 4'd3; bus.WD = 32'h33;
    expect_v("wb_mask_held", S_PM, 32'h0008);
    expect_v("wb_pb", S_PB, BYP ? 32'h0 : 32'h1);
    expect_v("wb_stall", S_ST, BYP ? 32'h0 : 32'h1);
    expect_v("wb_db", S_DB, BYP ? 32'h33 : 32'h0);
    sample();

    cyc(); idle();
    bus.RB = 4'd3;
    expect_v("after_wb_mask", S_PM, BYP ? 32'h0010 : 32'h0);
    expect_v("after_wb_pb", S_PB, 32'h0);
    expect_v("after_wb_db", S_DB, 32'h33);
    sample();

    cyc(); idle();
    bus.WE = 1'b1; bus.WA = 4'd4; bus.WD = 32'h44;
    cyc(); idle();
    bus.RA = 4'd4;
    expect_v("clr4_mask", S_PM, 32'h0);
    expect_v("clr4_da", S_DA, 32'h44);
    sample();

    // Same-register write-back clear and issue set.
    cyc(); idle();
    bus.IssueV = 1'b1; bus.IssueDst = 4'd7;
    expect_v("issue7_stall", S_ST, 32'h0);
    sample();

    cyc(); idle();
    bus.IssueV = 1'b1; bus.IssueDst = 4'd7; bus.RA = 4'd1; bus.RB = 4'd2;
    bus.WE = 1'b1; bus.WA = 4'd7; bus.WD = 32'h77;
    expect_v("setclr_mask_pre", S_PM, 32'h0080);
    expect_v("setclr_stall", S_ST, BYP ? 32'h0 : 32'h1);
    sample();

    cyc(); idle();
    bus.RA = 4'd7;
    expect_v("setclr_mask_post", S_PM, BYP ? 32'h0080 : 32'h0);
    expect_v("setclr_da", S_DA, 32'h77);
    sample();

    // Build PendMask = 0x00F0, then reset asynchronously mid-cycle.
    for (int k = 4; k < 8; k++) begin
      cyc(); idle();
      bus.IssueV = 1'b1; bus.IssueDst = k[3:0];
      bus.WE = (k == 4); bus.WA = 4'd7; bus.WD = 32'h77;
    end
    cyc(); idle();
    bus.RA = 4'd5;
    expect_v("f0_mask", S_PM, 32'h00F0);
    expect_v("f0_pa", S_PA, 32'h1);
    sample();

    cyc(); idle();
    bus.WE = 1'b1; bus.WA = 4'd9; bus.WD = 32'h99;
    bus.RA = 4'd5; bus.RB = 4'd1;
    #1 Clr_ = 1'b0;
    #1;
    expect_v("arst_mask", S_PM, 32'h0);
    expect_v("arst_da", S_DA, 32'h0);
    expect_v("arst_db", S_DB, 32'h0);
    expect_v("arst_pa", S_PA, 32'h0);
    expect_v("arst_stall", S_ST, 32'h0);
    -> chk_ev;
    #1;
    Clr_ = 1'b1;

    cyc(); idle();
    bus.RA = 4'd9; bus.RB = 4'd7;
    expect_v("post_arst_wr", S_DA, 32'h99);
    expect_v("post_arst_r7", S_DB, 32'h0);
    expect_v("post_arst_mask", S_PM, 32'h0);
    sample();

    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Register file with integrated scoreboard; sits directly downstream of the per-register storage elements, wrapping NREG words of clearable, load-enabled storage behind two combinational read ports, one write-back port, and issue-side hazard tracking. Register 0 is hardwired to zero. A per-register pending bit marks registers whose producer has issued but not yet written back. `Stall` tells the issue stage to hold an instruction whose sources or destination are still pending.

## Interface
Parameters:
- `N`, 32, data width
- `NREG`, 16, number of registers, power of two
- `AW`, 4, address width, log2(NREG)

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `Clr_`  in  1  asynchronous, active-low reset (one clock; reset asynchronous active-low)
- `RA`  in  AW  source A address of the issuing instruction
- `RB`  in  AW  source B address of the issuing instruction
- `DA`  out  N  read data for `RA`
- `DB`  out  N  read data for `RB`
- `WE`  in  1  write-back valid
- `WA`  in  AW  write-back address
- `WD`  in  N  write-back data
- `IssueV`  in  1  issue stage presents an instruction this cycle
- `IssueDst`  in  AW  destination of the issuing instruction
- `PendA`  out  1  source A is pending
- `PendB`  out  1  source B is pending
- `Stall`  out  1  issue must be held this cycle
- `PendMask`  out  NREG  registered pending bits, bit i = register i

## Operation
- Storage:
  - NREG×N words.
  - Word 0 reads 0 at all times.
  - Writes to address 0 are dropped.
- Write:
  - On posedge with `WE`=1 and `WA`≠0: `mem[WA]` ← `WD`.
  - Same posedge: `pend[WA]` ← 0.
- Read:
  - `DA`/`DB` are combinational from `mem` (see Configuration).
- Pending:
  - `PendA` = `pend_eff[RA]`; `PendB` = `pend_eff[RB]`; `PendD` = `pend_eff[IssueDst]`.
  - `pend_eff` = registered `pend`, except as modified by bypass.
  - `pend[0]` is always 0.
- Stall:
  - `Stall` = `IssueV` & (`PendA` | `PendB` | `PendD`).
  - Covers RAW hazards on both sources and WAW on the destination.
- Issue:
  - On posedge with `IssueV`=1, `Stall`=0, `IssueDst`≠0: `pend[IssueDst]` ← 1.
  - While `Stall`=1 the issue is ignored; the issue stage re-presents it.
- Simultaneous write-back clear and issue set on the same register: set wins, `pend` = 1.
- Write-back to a non-pending register: data is written, `pend` stays 0. This is legal.
- Reset:
  - `Clr_`=0 immediately, without a clock edge, zeroes all `mem` words and all `pend` bits.
  - Resulting outputs: `DA`=`DB`=0, `PendMask`=0, `PendA`=`PendB`=0, `Stall`=0.
  - Reset dominates `clk`, `WE` and `IssueV`, including mid-operation.

## Timing
- Read path:
  - Combinational, zero latency.
  - Without bypass, a write becomes visible the cycle after its posedge.
- `PendMask` updates one cycle after an issue or write-back.
- `Stall`, `PendA`, `PendB` are combinational from inputs and registered state.
- No output is registered except `PendMask`.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Read data: if `WE`=1, `WA`≠0 and `RA`=`WA`, `DA`=`WD` in the same cycle. Likewise `DB` for `RB`.
  - Pending: `pend_eff[WA]` reads 0 in that cycle, so a same-cycle write-back releases the stall.
- `REGFILE_BYPASS_EN` undefined:
  - `DA`/`DB` return the stored value.
  - `pend_eff` = `pend`, so a dependent instruction stalls through the write-back cycle.

## Test plan
- Reset: pulse `Clr_` low between clock edges → `DA`, `DB`, `PendMask` all 0 immediately; the following clock with `WE`=1 still writes normally once `Clr_`=1.
- Write then read: `WE`=1, `WA`=5, `WD`=0xDEADBEEF, then `RA`=5 next cycle → `DA`=0xDEADBEEF. With bypass, `RA`=5 in the same cycle → `DA`=0xDEADBEEF.
- Zero register: `WE`=1, `WA`=0, `WD`=0x1234; `IssueV`=1, `IssueDst`=0 → `DA`=0 with `RA`=0, `PendMask[0]`=0.
- RAW stall:
  - Issue `IssueDst`=3 → `PendMask`=0x0008.
  - Then `IssueV`=1, `RB`=3 → `PendB`=1, `Stall`=1.
  - `WE`, `WA`=3 → `PendMask`=0 next cycle.
  - Stall releases: same cycle with bypass, next cycle without.
- Simultaneous set/clear (bypass on):
  - Starting state `pend[7]`=1.
  - Stimulus: `WE`, `WA`=7, `IssueV`, `IssueDst`=7, sources clean.
  - Required: `Stall`=0, and `PendMask[7]`=1 after the edge.
- Async reset mid-operation: `PendMask`=0x00F0 with `WE` active; `Clr_`=0 mid-cycle → `PendMask`=0 and all reads 0 before the next posedge.
